// File: rtl/text_fetch_arbiter.sv
// Text-mode fetch scheduler for an 80x30 grid of 8x16 glyphs, arbitrating the text RAM with a host writer.
// Optional blinking block cursor on glyph rows 14-15 when TEXT_CURSOR_EN is defined.
module text_fetch_arbiter #(
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35,
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int CELLS       = COLS * ROWS
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        wr_req,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        ram_en,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        rom_en,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
`ifdef TEXT_CURSOR_EN
  input  logic [11:0] cur_addr,
  input  logic        cur_on,
`endif
  output logic        box_time
);

  // Each cell is read 5 pixels before it is shown: read, ROM, latch, (gap), load.
  localparam logic [9:0]  H_ISSUE0     = 10'(H_ACT_START - 5);
  localparam logic [9:0]  H_LAST_ISSUE = 10'(H_ACT_START - 5 + 8 * (COLS - 1));
  localparam logic [9:0]  H_DRAIN_END  = 10'(H_ACT_START - 1 + 8 * (COLS - 1));
  localparam logic [9:0]  H_LINE_END   = 10'd798;
  localparam logic [9:0]  V_FIRST      = 10'(V_ACT_START);
  localparam logic [9:0]  V_LAST       = 10'(V_ACT_START + 16 * ROWS - 1);
  localparam logic [11:0] CELLS_L      = 12'(CELLS);
  localparam logic [11:0] ROW_STEP     = 12'(COLS);

  typedef enum logic [1:0] {S_BLANK, S_FETCH, S_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_shift, r_next_byte;
  logic [6:0]  r_col;
  logic [11:0] r_line_base;
  logic        r_base_ok;

  logic        w_active, w_issue, w_rom_slot, w_latch, w_load;
  logic [8:0]  w_vrel;
  logic [3:0]  w_glyph_row;
  logic [4:0]  w_text_row;
  logic [2:0]  w_phase;
  logic [11:0] w_base_calc, w_base_cur, w_disp_addr;
  logic [7:0]  w_glyph;

  assign w_active    = (v_cnt >= V_FIRST) && (v_cnt <= V_LAST);
  assign w_vrel      = v_cnt[8:0] - V_FIRST[8:0];
  assign w_glyph_row = w_vrel[3:0];
  assign w_text_row  = w_vrel[8:4];
  assign w_phase     = h_cnt[2:0] - H_ISSUE0[2:0];

  // Row base = 80*text_row as 64*row + 16*row; only used to resynchronise after a reset.
  assign w_base_calc = {1'b0, w_text_row, 6'd0} + {3'd0, w_text_row, 4'd0};
  assign w_base_cur  = r_base_ok ? r_line_base : w_base_calc;
  assign w_disp_addr = w_base_cur + {5'd0, r_col};

  assign w_issue    = ((r_state == S_BLANK) && (h_cnt == H_ISSUE0) && w_active) ||
                      ((r_state == S_FETCH) && (w_phase == 3'd0));
  assign w_rom_slot = (r_state != S_BLANK) && (w_phase == 3'd1);
  assign w_latch    = (r_state != S_BLANK) && (w_phase == 3'd2);
  assign w_load     = (r_state != S_BLANK) && (w_phase == 3'd4);

  // NOTE: every output gets a default before any branch so this block never infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    wr_ack      = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    rom_en      = 1'b0;
    rom_addr    = '0;
    case (r_state)
      S_BLANK: if (w_issue) w_state_nxt = S_FETCH;
      S_FETCH: if (h_cnt >= H_LAST_ISSUE) w_state_nxt = S_DRAIN;
      S_DRAIN: if (h_cnt >= H_DRAIN_END) w_state_nxt = S_BLANK;
      default: w_state_nxt = S_BLANK;
    endcase
    if (!rst) begin
      if (w_issue) begin
        ram_en   = 1'b1;
        ram_addr = w_disp_addr;
      end else if (wr_req) begin
        wr_ack = 1'b1;
        if (wr_addr < CELLS_L) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
      end
      if (w_rom_slot) begin
        rom_en   = 1'b1;
        rom_addr = {ram_rdata, w_glyph_row};
      end
    end
  end

`ifdef TEXT_CURSOR_EN
  localparam logic [9:0] V_FRAME_END = 10'd523;
  logic [4:0]  r_frame_cnt;
  logic [11:0] r_fetch_addr;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_fetch_addr <= '0;
    end else begin
      if (v_cnt == V_FRAME_END && h_cnt == H_LINE_END) r_frame_cnt <= r_frame_cnt + 5'd1;
      if (w_issue) r_fetch_addr <= w_disp_addr;
    end
  end

  assign w_glyph = (cur_on && r_frame_cnt[4] && (r_fetch_addr == cur_addr) &&
                    (w_glyph_row[3:1] == 3'b111)) ? ~rom_data : rom_data;
`else
  assign w_glyph = rom_data;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_state     <= S_BLANK;
      r_shift     <= '0;
      r_next_byte <= '0;
      r_col       <= '0;
      r_line_base <= '0;
      r_base_ok   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue)                r_col <= r_col + 7'd1;
      else if (r_state == S_BLANK) r_col <= '0;
      if (w_latch) r_next_byte <= w_glyph;
      r_shift <= w_load ? r_next_byte : {r_shift[6:0], 1'b0};
      if (v_cnt == V_FIRST && h_cnt == 10'd0) begin
        r_line_base <= '0;
        r_base_ok   <= 1'b1;
      end else if (w_active && h_cnt == H_LINE_END && w_glyph_row == 4'hF) begin
        r_line_base <= w_base_cur + ROW_STEP;
        r_base_ok   <= 1'b1;
      end else if (w_active && !r_base_ok) begin
        r_line_base <= w_base_calc;
        r_base_ok   <= 1'b1;
      end
    end
  end

  assign box_time = r_shift[7] & ~rst;

endmodule

// File: doc/text_fetch_arbiter.md
Name: text_fetch_arbiter

Overview:
- Text-mode fetch scheduler for the 640x480 VGA/HDMI pipeline. Grid is 80x30 cells, 8x16 glyphs.
- From the VGA sync counters it sequences text-buffer RAM reads and character-ROM reads, then serialises glyph bits into `box_time` for the sync block's colour mux.
- Shares the single text-buffer RAM port between display fetch (fixed priority) and a host write requester.

Parameters:
- `H_ACT_START`, 144, first active h_cnt.
- `V_ACT_START`, 35, first active v_cnt.
- `COLS`, 80, character columns per row.
- `ROWS`, 30, character rows.
- `CELLS`, 2400, text buffer depth (`COLS`*`ROWS`).

Ports:
- `pix_clk` in 1: pixel clock, 25 MHz.
- `rst` in 1: synchronous, active-high reset.
- `h_cnt` in 10: horizontal count, 0..798.
- `v_cnt` in 10: vertical count, 0..523.
- `wr_req` in 1: host write request, held until `wr_ack`.
- `wr_addr` in 12: host cell address.
- `wr_data` in 8: host character code.
- `wr_ack` out 1: one-cycle pulse when the host request is consumed.
- `ram_en` out 1: text RAM enable.
- `ram_we` out 1: text RAM write enable.
- `ram_addr` out 12: text RAM address.
- `ram_wdata` out 8: text RAM write data.
- `ram_rdata` in 8: text RAM read data, valid 1 cycle after `ram_en`.
- `rom_en` out 1: character ROM enable.
- `rom_addr` out 12: {char_code[7:0], glyph_row[3:0]}.
- `rom_data` in 8: glyph row, MSB = leftmost pixel, valid 1 cycle after `rom_en`.
- `box_time` out 1: current pixel is a glyph foreground pixel.

Behaviour:
- Reset: all outputs 0. Shift register, next_byte, column counter, line base and FSM are cleared; FSM goes to `S_BLANK`.
- Active line: `v_cnt` in [35, 514]. Within it, glyph_row = (`v_cnt`-35)[3:0] and text_row = (`v_cnt`-35)>>4.
- line_base register:
  - Cleared when `v_cnt`=35 and `h_cnt`=0.
  - Incremented by 80 at `h_cnt`=798 when glyph_row=15.
  - No multiplier is used.
- FSM states:
  - `S_BLANK` → `S_FETCH` at `h_cnt`=139 on an active line.
  - `S_FETCH` → `S_DRAIN` after the read for column 79 is issued (`h_cnt`=771).
  - `S_DRAIN` → `S_BLANK` after the last shift-register load at `h_cnt`=775.
- Per cell k (0..79), issue-slot timing:
  - `h_cnt`=139+8k: display read, `ram_en`=1, `ram_we`=0, `ram_addr` = line_base + k.
  - `h_cnt`=140+8k: `rom_en`=1, `rom_addr` = {`ram_rdata`, glyph_row}.
  - End of 141+8k: `rom_data` latched into next_byte.
  - End of 143+8k: shift register loaded from next_byte.
  - Other edges: shift register shifts left, zero fill.
- `box_time` = shift_reg[7], combinational from the register, so it aligns with `h_cnt`=144+8k..151+8k.
- Outside the active window the shift register holds 0, so `box_time`=0 at `h_cnt`≥784 and on blank lines.
- Arbitration:
  - The display owns the RAM only in issue slots; the host may write in any other cycle.
  - On grant: `ram_en`=1, `ram_we`=1, `ram_addr`=`wr_addr`, `ram_wdata`=`wr_data`, `wr_ack`=1, all in the same cycle.
  - A request arriving in an issue slot is granted the next cycle; maximum wait is 1 cycle.
  - `wr_addr` ≥ 2400: acknowledged, with `ram_en`=`ram_we`=0 (dropped).
  - After `wr_ack`, a still-high `wr_req` is a new request; back-to-back writes are allowed every non-slot cycle.
- Reset mid-line: fetch is abandoned and `box_time`=0 until the next active line's first load.
- A pending `wr_req` is not acknowledged in the reset cycle. It is serviced the first non-slot cycle after `rst` deasserts.

Optional Feature:
- Macro `TEXT_CURSOR_EN`.
- When defined:
  - Added ports `cur_addr` in 12 and `cur_on` in 1.
  - A 5-bit frame counter increments at `v_cnt`=523, `h_cnt`=798 and is reset to 0.
  - When `cur_on`=1, frame_cnt[4]=1 and the fetched cell equals `cur_addr`: next_byte is inverted (~`rom_data`) for glyph rows 14 and 15 only.
- When undefined: ports are absent, no counter, glyphs are never modified.

Test Plan:
- RAM cell 0 = 0x41, ROM {0x41,0} = 0xA5, frame at `v_cnt`=35 → `box_time` = 1,0,1,0,0,1,0,1 at `h_cnt` 144..151; `ram_addr`=0 at `h_cnt`=139.
- Line at `v_cnt`=51 (text_row 1) → `ram_addr` = 80..159 at `h_cnt` = 139, 147, …, 771; `rom_addr` low nibble = 0.
- `wr_req` with `wr_addr`=5, `wr_data`=0x30 asserted at `h_cnt`=139, `v_cnt`=40 → `wr_ack`, `ram_we`=1 at `h_cnt`=140; no write at 139.
- `wr_req` during `v_cnt`=10 held 4 cycles with changing addresses → 4 consecutive `wr_ack` pulses, `ram_we`=1 each cycle.
- `wr_addr`=2400 → `wr_ack`=1, `ram_en`=0.
- `rst` at `h_cnt`=300, `v_cnt`=100 for 2 cycles → `box_time`=0 and all outputs 0 during reset. `box_time`=0 for the rest of the line; fetch resumes at `h_cnt`=139 on the next line with correct `ram_addr`.
